// File: rtl/hex_display_scan.sv
// -----------------------------------------------------------------------------
// hex_display_scan
//
// Time-multiplexed driver for a DIGITS-digit common-anode 7-segment display.
// Each digit gets a slot of REFRESH_DIV clocks. The first BLANK_CYCLES clocks
// of every slot keep all anodes off so the previous digit's pattern cannot
// ghost onto the next one. The displayed data comes from shadow registers that
// are reloaded only at the frame boundary, so a frame never mixes two values.
// When freeze is high the shadow is not reloaded. Leading-zero suppression and
// per-digit decimal points are applied to the shadow values.
//
// Parameters:
//   DIGITS       number of digits scanned (1..8)
//   REFRESH_DIV  clocks per digit slot (>= 2)
//   BLANK_CYCLES dark clocks at the start of each slot (< REFRESH_DIV)
//   ACTIVE_LOW   1: seg/dp/an asserted low, 0: asserted high
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       hex nibbles, nibble i drives digit i (digit 0 = rightmost)
//   digit_en    per-digit enable, 0 blanks the digit
//   dp_in       per-digit decimal point request
//   lz_en       leading-zero suppression enable
//   freeze      1 holds the shadow registers at the frame boundary
//   seg         segments a..g on bits 0..6 (registered)
//   dp          decimal point (registered)
//   an          anode selects, one-hot or none (registered)
//   frame_done  one-clock pulse at each frame boundary (registered)
// -----------------------------------------------------------------------------
module hex_display_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    input  logic                  freeze,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Deasserted levels of the display pins in the selected polarity.
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex nibble to segment pattern, active-high, bit order g..a.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b1111100;
            4'hC:    pat = 7'b0111001;
            4'hD:    pat = 7'b1011110;
            4'hE:    pat = 7'b1111001;
            4'hF:    pat = 7'b1110001;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // Scan state
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;

    // Shadow copy of the display inputs, refreshed once per frame
    logic [4*DIGITS-1:0] sh_val_r;
    logic [DIGITS-1:0]   sh_en_r;
    logic [DIGITS-1:0]   sh_dp_r;
    logic                sh_lz_r;

    // Output registers
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    // Combinational helpers
    logic                slot_end_s;
    logic                frame_end_s;
    logic                blank_done_s;
    logic [DIGITS-1:0]   supp_s;
    logic                zero_run_s;
    logic [3:0]          cur_nib_s;
    logic                cur_en_s;
    logic                cur_dp_s;
    logic                cur_supp_s;
    logic                lit_s;
    logic [DIGITS-1:0]   an_hi_s;
    logic [6:0]          seg_hi_s;
    logic                dp_hi_s;
    logic [DIGITS-1:0]   an_nxt_s;
    logic [6:0]          seg_nxt_s;
    logic                dp_nxt_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

    // With no guard cycles the comparison would be constant, so it is only
    // built when there is something to compare against.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_done_s = 1'b1;
        end else begin : g_blank
            assign blank_done_s = (cnt_r >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            if (slot_end_s) begin
                cnt_r <= {CNT_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                idx_r <= idx_r;
            end
        end
    end

    // Shadow registers: reloaded only at the frame boundary unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val_r <= {(4*DIGITS){1'b0}};
            sh_en_r  <= {DIGITS{1'b0}};
            sh_dp_r  <= {DIGITS{1'b0}};
            sh_lz_r  <= 1'b0;
        end else if (frame_end_s && !freeze) begin
            sh_val_r <= value;
            sh_en_r  <= digit_en;
            sh_dp_r  <= dp_in;
            sh_lz_r  <= lz_en;
        end else begin
            sh_val_r <= sh_val_r;
            sh_en_r  <= sh_en_r;
            sh_dp_r  <= sh_dp_r;
            sh_lz_r  <= sh_lz_r;
        end
    end

    // Leading-zero map: walk from the most significant digit down, digit i is
    // suppressed while every nibble from the top down to i is zero. Digit 0 is
    // never suppressed so a zero value still shows a single 0.
    always_comb begin
        supp_s     = {DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (sh_val_r[4*i +: 4] == 4'h0);
            supp_s[i]  = sh_lz_r & zero_run_s;
        end
    end

    // Current-digit selection and next output pattern in asserted polarity.
    always_comb begin
        cur_nib_s  = 4'(sh_val_r >> {idx_r, 2'b00});
        cur_en_s   = 1'(sh_en_r >> idx_r);
        cur_dp_s   = 1'(sh_dp_r >> idx_r);
        cur_supp_s = 1'(supp_s >> idx_r);
        lit_s      = blank_done_s && cur_en_s && !cur_supp_s;
        an_hi_s    = {DIGITS{1'b0}};
        seg_hi_s   = 7'h00;
        dp_hi_s    = 1'b0;
        if (lit_s) begin
            an_hi_s  = DIGITS'(1'b1) << idx_r;
            seg_hi_s = seg_decode(cur_nib_s);
            dp_hi_s  = cur_dp_s;
        end else begin
            an_hi_s  = {DIGITS{1'b0}};
            seg_hi_s = 7'h00;
            dp_hi_s  = 1'b0;
        end
    end

    // Apply the pin polarity.
    always_comb begin
        an_nxt_s  = an_hi_s;
        seg_nxt_s = seg_hi_s;
        dp_nxt_s  = dp_hi_s;
        if (ACTIVE_LOW) begin
            an_nxt_s  = ~an_hi_s;
            seg_nxt_s = ~seg_hi_s;
            dp_nxt_s  = ~dp_hi_s;
        end else begin
            an_nxt_s  = an_hi_s;
            seg_nxt_s = seg_hi_s;
            dp_nxt_s  = dp_hi_s;
        end
    end

    // Output registers: one clock behind the scan/shadow state, no input paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            an_r         <= an_nxt_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hex_display_scan.sv
module tb_hex_display_scan;

    localparam int DG = 4;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int FRAME = DG * RD;

    // Segment table straight from the hex glyph list (g..a, active-high).
    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    digit_en;
    logic [3:0]    dp_in;
    logic          lz_en;
    logic          freeze;

    logic [6:0]    seg_lo, seg_hi;
    logic          dp_lo, dp_hi;
    logic [3:0]    an_lo, an_hi;
    logic          fd_lo, fd_hi;

    int            checks;
    int            errors;

    // Reference model: absolute clock count since reset plus shadow copy
    int            t;
    logic [15:0]   m_val;
    logic [3:0]    m_en;
    logic [3:0]    m_dp;
    logic          m_lz;

    hex_display_scan #(.DIGITS(DG), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .value(value), .digit_en(digit_en), .dp_in(dp_in),
        .lz_en(lz_en), .freeze(freeze), .seg(seg_lo), .dp(dp_lo), .an(an_lo), .frame_done(fd_lo)
    );

    hex_display_scan #(.DIGITS(DG), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .value(value), .digit_en(digit_en), .dp_in(dp_in),
        .lz_en(lz_en), .freeze(freeze), .seg(seg_hi), .dp(dp_hi), .an(an_hi), .frame_done(fd_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t     = 0;
        m_val = 16'h0000;
        m_en  = 4'h0;
        m_dp  = 4'h0;
        m_lz  = 1'b0;
    endtask

    // One clock: predict the outputs from the model state before the edge,
    // apply the frame-boundary capture, clock, then compare both DUTs.
    task automatic step();
        int         c;
        int         d;
        logic [3:0] nib;
        logic       sup;
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        logic [3:0] e_an_n;
        logic [6:0] e_seg_n;
        logic       e_dp_n;
        c     = t % RD;
        d     = (t / RD) % DG;
        nib   = 4'((m_val >> (4 * d)) & 16'h000F);
        sup   = m_lz && (d >= 1) && ((m_val >> (4 * d)) == 16'h0000);
        lit   = (c >= BL) && m_en[d] && !sup;
        e_an  = lit ? 4'(1 << d) : 4'h0;
        e_seg = lit ? SEG_TAB[nib] : 7'h00;
        e_dp  = lit && m_dp[d];
        e_fd  = (c == RD - 1) && (d == DG - 1);
        if (e_fd && !freeze) begin
            m_val = value;
            m_en  = digit_en;
            m_dp  = dp_in;
            m_lz  = lz_en;
        end
        t++;
        e_an_n  = ~e_an;
        e_seg_n = ~e_seg;
        e_dp_n  = ~e_dp;
        @(posedge clk);
        #1;
        chk("an_lo",  32'(an_lo),  32'(e_an_n));
        chk("seg_lo", 32'(seg_lo), 32'(e_seg_n));
        chk("dp_lo",  32'(dp_lo),  32'(e_dp_n));
        chk("fd_lo",  32'(fd_lo),  32'(e_fd));
        chk("an_hi",  32'(an_hi),  32'(e_an));
        chk("seg_hi", 32'(seg_hi), 32'(e_seg));
        chk("dp_hi",  32'(dp_hi),  32'(e_dp));
        chk("fd_hi",  32'(fd_hi),  32'(e_fd));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an_lo"},  32'(an_lo),  32'h0000000F);
        chk({tag, "_seg_lo"}, 32'(seg_lo), 32'h0000007F);
        chk({tag, "_dp_lo"},  32'(dp_lo),  32'h00000001);
        chk({tag, "_fd_lo"},  32'(fd_lo),  32'h00000000);
        chk({tag, "_an_hi"},  32'(an_hi),  32'h00000000);
        chk({tag, "_seg_hi"}, 32'(seg_hi), 32'h00000000);
        chk({tag, "_dp_hi"},  32'(dp_hi),  32'h00000000);
        chk({tag, "_fd_hi"},  32'(fd_hi),  32'h00000000);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        value    = 16'h0000;
        digit_en = 4'h0;
        dp_in    = 4'h0;
        lz_en    = 1'b0;
        freeze   = 1'b0;
        model_reset();

        // Reset state, then release with 1234 on all digits
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        value    = 16'h1234;
        digit_en = 4'hF;
        #2;
        rst_n = 1'b1;

        // Dark first frame, load at its boundary, then 4,3,2,1
        steps(FRAME);
        steps(FRAME / 2);

        // Mid-frame change: must not tear, ABCD appears after the boundary
        value = 16'hABCD;
        steps(FRAME / 2);
        steps(FRAME);

        // Frozen: later changes never reach the display
        freeze = 1'b1;
        value  = 16'h5678;
        dp_in  = 4'hA;
        steps(2 * FRAME);

        // Leading zeros with all decimal points requested
        freeze = 1'b0;
        value  = 16'h0070;
        lz_en  = 1'b1;
        dp_in  = 4'b1111;
        steps(2 * FRAME);

        // All zero: only digit 0 lit
        value = 16'h0000;
        steps(2 * FRAME);

        // Digit enables 0101
        value    = 16'h9E0F;
        lz_en    = 1'b0;
        dp_in    = 4'b0011;
        digit_en = 4'b0101;
        steps(2 * FRAME);

        // Randomised phase, inputs change at arbitrary clocks
        for (int r = 0; r < 30; r++) begin
            value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            digit_en = 4'($urandom);
            dp_in    = 4'($urandom);
            lz_en    = 1'($urandom);
            freeze   = ($urandom_range(0, 3) == 0);
            steps($urandom_range(1, 40));
        end

        // Asynchronous reset while digit 1 is lit mid-slot
        value    = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        lz_en    = 1'b0;
        freeze   = 1'b0;
        steps(FRAME);
        while ((t % FRAME) != 14) begin
            step();
        end
        steps(FRAME);
        while ((t % FRAME) != 14) begin
            step();
        end
        chk("pre_rst_an_lo", 32'(an_lo), 32'h0000000D);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("hold");
        #2;
        rst_n = 1'b1;

        // Restart: dark first frame, then 1234 again
        steps(2 * FRAME + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
